// File: rtl/lfsr_range_rng_pkg.sv
// Shared types and helpers for the range-reduced LFSR random source.
// Holds the FSM state encoding, game-level defaults and the LFSR step function.
package lfsr_range_rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REDUCE = 2'd2
    } rng_state_e;

    // Game-level defaults: 531 horizontal spawn columns on a 10-bit LFSR.
    localparam int unsigned DEF_WIDTH     = 10;
    localparam logic [31:0] DEF_TAPS      = 32'h0000_0240;
    localparam int unsigned DEF_SHIFTS    = 10;
    localparam int unsigned DEF_MAX_VAL   = 530;
    localparam int unsigned DEF_RESET_RND = 300;

    // One Fibonacci step at up to 32 bits; a zero result is replaced by all-ones
    // so the register can never lock up.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur,
                                              input logic [31:0] taps,
                                              input int unsigned width);
        logic [31:0] mask;
        logic [31:0] nxt;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        nxt  = ((cur << 1) | {31'd0, ^(cur & taps & mask)}) & mask;
        if (nxt == 32'd0) begin
            nxt = mask;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_range_rng_core.sv
// Free-running Fibonacci LFSR with seed load and lock-up guard.
// Also exposes the value the register takes on the next edge.
module lfsr_range_rng_core
    import lfsr_range_rng_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] lfsr_o,
    output logic [WIDTH-1:0] lfsr_next_o
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = WIDTH'(lfsr_step(32'(lfsr_q), 32'(TAPS), WIDTH));
        if (seed_load_i) begin
            lfsr_d = (seed_i == '0) ? ONES : seed_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= ONES;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o      = lfsr_q;
    assign lfsr_next_o = lfsr_d;

endmodule

// File: rtl/lfsr_range_rng.sv
// Random sample source: req/valid handshake, SHIFTS stir cycles, then exact
// reduction into 0..MAX_VAL by repeated subtraction of MAX_VAL+1.
module lfsr_range_rng
    import lfsr_range_rng_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEF_TAPS),
    parameter int unsigned      SHIFTS    = DEF_SHIFTS,
    parameter int unsigned      MAX_VAL   = DEF_MAX_VAL,
    parameter int unsigned      RESET_RND = DEF_RESET_RND
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    output logic             busy,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd,
    output rng_state_e       dbg_state,
    output logic [WIDTH-1:0] dbg_lfsr
);

    // Handshake: req is taken only on an edge where the FSM is IDLE and
    // seed_load is low; rnd_valid is a one-cycle pulse with rnd updated in
    // that same cycle, and rnd holds until the next pulse.

    localparam int unsigned      CW         = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
    localparam logic [CW-1:0]    LAST_SHIFT = CW'(SHIFTS - 1);
    localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MOD_W      = WIDTH'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] RESET_W    = WIDTH'(RESET_RND);

    rng_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] rnd_q;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] lfsr_cur;
    logic [WIDTH-1:0] lfsr_nxt;

    lfsr_range_rng_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk_i       (clk),
        .rst_i       (rst),
        .seed_load_i (seed_load),
        .seed_i      (seed),
        .lfsr_o      (lfsr_cur),
        .lfsr_next_o (lfsr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            rnd_q   <= RESET_W;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (seed_load) begin
                // Re-seeding aborts any sample in flight; rnd keeps its value.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (cnt_q == LAST_SHIFT) begin
                            w_q     <= lfsr_nxt;
                            state_q <= ST_REDUCE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_REDUCE: begin
                        if (w_q > MAX_W) begin
                            w_q <= w_q - MOD_W;
                        end else begin
                            rnd_q   <= w_q;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign rnd_valid = valid_q;
    assign rnd       = rnd_q;
    assign dbg_state = state_q;
    assign dbg_lfsr  = lfsr_cur;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Bench for lfsr_range_rng: a cycle scoreboard on the default instance plus
// forced-capture checks on a SHIFTS=1 instance.
module tb_lfsr_range_rng;
    import lfsr_range_rng_pkg::*;

    localparam int          W       = 10;
    localparam logic [9:0]  TAPS    = 10'h240;
    localparam int          S       = 10;
    localparam int          MAXV    = 530;
    localparam logic [9:0]  RST_RND = 10'd300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seed_load = 1'b0;
    logic [9:0] seed = '0;
    logic       req = 1'b0;
    logic       busy, rnd_valid;
    logic [9:0] rnd, dbg_lfsr;
    rng_state_e dbg_state;

    logic       seed_load1 = 1'b0;
    logic [9:0] seed1 = '0;
    logic       req1 = 1'b0;
    logic       busy1, rnd_valid1;
    logic [9:0] rnd1, dbg_lfsr1;
    rng_state_e dbg_state1;

    int tests = 0;
    int fails = 0;

    // Scoreboard model state for the default instance.
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    logic [9:0]   m_lfsr = 10'h3FF;
    logic [9:0]   m_rnd = RST_RND;
    bit           m_idle = 1'b1;
    int           elapsed = 0;

    lfsr_range_rng dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
        .busy(busy), .rnd_valid(rnd_valid), .rnd(rnd),
        .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
    );

    lfsr_range_rng #(.SHIFTS(1)) dut1 (
        .clk(clk), .rst(rst), .seed_load(seed_load1), .seed(seed1), .req(req1),
        .busy(busy1), .rnd_valid(rnd_valid1), .rnd(rnd1),
        .dbg_state(dbg_state1), .dbg_lfsr(dbg_lfsr1)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ref_step(input logic [9:0] v);
        logic [9:0] n;
        n = {v[8:0], ^(v & TAPS)};
        if (n == 10'd0) n = 10'h3FF;
        return n;
    endfunction

    function automatic logic [9:0] ref_unstep(input logic [9:0] n);
        return {n[0] ^ n[7], n[9:1]};
    endfunction

    function automatic logic [9:0] capture_of(input logic [9:0] v, input int shifts);
        logic [9:0] x;
        x = v;
        for (int i = 0; i <= shifts; i++) x = ref_step(x);
        return x;
    endfunction

    // Negedge scoreboard: check this cycle's outputs, then predict the next edge.
    task automatic sb_eval();
        logic [9:0] m_next;
        logic [9:0] e;
        logic [9:0] w;
        int         l;
        if (rst) begin
            m_lfsr = 10'h3FF;
            m_rnd  = RST_RND;
            m_idle = 1'b1;
            exp_q.delete();
            lat_q.delete();
        end else begin
            if (!m_idle) elapsed++;
            tests++;
            if (dbg_lfsr !== m_lfsr) begin
                fails++;
                $display("FAIL sb_lfsr: got %h expected %h at %0t", dbg_lfsr, m_lfsr, $time);
            end
            if (rnd_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected_valid: rnd %0d with nothing pending at %0t", rnd, $time);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    if (rnd !== e || elapsed != l) begin
                        fails++;
                        $display("FAIL sb_sample: rnd %0d lat %0d expected rnd %0d lat %0d", rnd, elapsed, e, l);
                    end
                    m_rnd  = e;
                    m_idle = 1'b1;
                end
            end else if (!m_idle && lat_q.size() > 0 && elapsed > lat_q[0]) begin
                tests++;
                fails++;
                $display("FAIL sb_timeout: no rnd_valid after %0d cycles, expected at %0d", elapsed, lat_q[0]);
                void'(exp_q.pop_front());
                void'(lat_q.pop_front());
                m_idle = 1'b1;
            end
            tests++;
            if (busy !== (m_idle ? 1'b0 : 1'b1)) begin
                fails++;
                $display("FAIL sb_busy: got %b expected %b at %0t", busy, !m_idle, $time);
            end
            tests++;
            if (rnd !== m_rnd) begin
                fails++;
                $display("FAIL sb_rnd_hold: got %0d expected %0d at %0t", rnd, m_rnd, $time);
            end
            if (seed_load) begin
                m_next = (seed == 10'd0) ? 10'h3FF : seed;
                if (!m_idle) begin
                    void'(exp_q.pop_front());
                    void'(lat_q.pop_front());
                    m_idle = 1'b1;
                end
            end else begin
                m_next = ref_step(m_lfsr);
                if (m_idle && req) begin
                    w = capture_of(m_lfsr, S);
                    exp_q.push_back(w % (MAXV + 1));
                    lat_q.push_back(S + 1 + int'(w) / (MAXV + 1));
                    m_idle  = 1'b0;
                    elapsed = -1;
                end
            end
            m_lfsr = m_next;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] seq [4];
        seq = '{10'h3FF, 10'h3FE, 10'h3FC, 10'h3F8};
        tests++;
        if (rnd !== RST_RND || rnd_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rnd %0d valid %b busy %b expected 300 0 0", rnd, rnd_valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (dbg_lfsr !== seq[i]) begin
                fails++;
                $display("FAIL reset_lfsr_seq[%0d]: got %h expected %h", i, dbg_lfsr, seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_single_req();
        logic [9:0] w;
        int         k;
        int         busy_cnt;
        int         pulses;
        logic [9:0] got;
        w = capture_of(m_lfsr, S);
        k = int'(w) / (MAXV + 1);
        busy_cnt = 0;
        pulses = 0;
        got = '0;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (busy) busy_cnt++;
            if (rnd_valid) begin
                pulses++;
                got = rnd;
            end
            tick();
        end
        tests++;
        if (busy_cnt != S + 1 + k) begin
            fails++;
            $display("FAIL single_busy_cycles: got %0d expected %0d", busy_cnt, S + 1 + k);
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL single_pulse_count: got %0d expected 1", pulses);
        end
        tests++;
        if (got !== 10'(w % (MAXV + 1)) || got > MAXV) begin
            fails++;
            $display("FAIL single_rnd: got %0d expected %0d", got, w % (MAXV + 1));
        end
    endtask

    task automatic test_forced_capture();
        logic [9:0] tgt  [3];
        logic [9:0] exp_r[3];
        int         exp_k[3];
        logic [9:0] s;
        int         lat;
        tgt   = '{10'd1000, 10'd531, 10'd530};
        exp_r = '{10'd469, 10'd0, 10'd530};
        exp_k = '{1, 1, 0};
        for (int t = 0; t < 3; t++) begin
            s = ref_unstep(ref_unstep(tgt[t]));
            seed1 = s;
            seed_load1 = 1'b1;
            tick();
            seed_load1 = 1'b0;
            tests++;
            if (dbg_lfsr1 !== s) begin
                fails++;
                $display("FAIL forced_seed_load[%0d]: lfsr %h expected %h", t, dbg_lfsr1, s);
            end
            req1 = 1'b1;
            tick();
            req1 = 1'b0;
            lat = 0;
            for (int n = 1; n <= 20 && lat == 0; n++) begin
                tick();
                if (rnd_valid1) lat = n;
            end
            tests++;
            if (lat != 2 + exp_k[t]) begin
                fails++;
                $display("FAIL forced_latency[%0d]: got %0d expected %0d", t, lat, 2 + exp_k[t]);
            end
            tests++;
            if (rnd1 !== exp_r[t] || busy1 !== 1'b0 || dbg_state1 !== ST_IDLE) begin
                fails++;
                $display("FAIL forced_rnd[%0d]: rnd %0d busy %b expected rnd %0d busy 0", t, rnd1, busy1, exp_r[t]);
            end
            tick();
            tests++;
            if (rnd_valid1 !== 1'b0 || rnd1 !== exp_r[t]) begin
                fails++;
                $display("FAIL forced_pulse_width[%0d]: valid %b rnd %0d", t, rnd_valid1, rnd1);
            end
        end
    endtask

    task automatic test_seed();
        seed = 10'd0;
        seed_load = 1'b1;
        req = 1'b1;
        tick();
        seed_load = 1'b0;
        req = 1'b0;
        tests++;
        if (dbg_lfsr !== 10'h3FF || busy !== 1'b0) begin
            fails++;
            $display("FAIL seed_zero: lfsr %h busy %b expected 3ff 0", dbg_lfsr, busy);
        end
        seed = 10'(32'h100 + $urandom_range(0, 255));
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tests++;
        if (dbg_lfsr !== seed) begin
            fails++;
            $display("FAIL seed_value: lfsr %h expected %h", dbg_lfsr, seed);
        end
    endtask

    task automatic test_abort(input bit in_reduce);
        logic [9:0] saved;
        int         stray;
        bit         reached;
        saved = rnd;
        req = 1'b1;
        tick();
        req = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (in_reduce ? (dbg_state == ST_REDUCE) : (dbg_state == ST_SHIFT && i >= 3)) reached = 1'b1;
            else tick();
        end
        tests++;
        if (!reached) begin
            fails++;
            $display("FAIL abort_reach_state: state %0d not reached, in_reduce %0d", dbg_state, in_reduce);
        end
        seed = 10'(32'h80 + $urandom_range(0, 127));
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        stray = 0;
        tests++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE || rnd !== saved) begin
            fails++;
            $display("FAIL abort_state: busy %b state %0d rnd %0d expected 0 0 %0d", busy, dbg_state, rnd, saved);
        end
        for (int i = 0; i < S + 6; i++) begin
            if (rnd_valid) stray++;
            tick();
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL abort_no_valid: got %0d pulses expected 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, over, zeros, first, second;
        pulses = 0;
        over = 0;
        zeros = 0;
        first = -1;
        second = -1;
        req = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (rnd_valid) begin
                pulses++;
                if (rnd > MAXV) over++;
            end
            if (dbg_lfsr == 10'd0) zeros++;
            if (dbg_lfsr == 10'h3FF) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        req = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick();
        tick();
        tests++;
        if (pulses < 10000 / (S + 3) || over != 0) begin
            fails++;
            $display("FAIL b2b_pulses: %0d pulses, %0d above max", pulses, over);
        end
        tests++;
        if (zeros != 0) begin
            fails++;
            $display("FAIL b2b_lfsr_zero: seen zero %0d times expected 0", zeros);
        end
        tests++;
        if (second - first != 1023) begin
            fails++;
            $display("FAIL b2b_period: got %0d expected 1023", second - first);
        end
        tests++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: %0d pending busy %b expected 0 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid_reduce();
        bit reached;
        req = 1'b1;
        tick();
        req = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (dbg_state == ST_REDUCE) reached = 1'b1;
            else tick();
        end
        tests++;
        if (!reached) begin
            fails++;
            $display("FAIL rst_reach_reduce: state %0d", dbg_state);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (rnd !== RST_RND || rnd_valid !== 1'b0 || busy !== 1'b0 ||
            dbg_lfsr !== 10'h3FF || dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL rst_async: rnd %0d valid %b busy %b lfsr %h state %0d", rnd, rnd_valid, busy, dbg_lfsr, dbg_state);
        end
        tick();
        tick();
        rst = 1'b0;
        test_single_req();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        test_single_req();
        test_forced_capture();
        test_seed();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_reset_mid_reduce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_range_rng.md
Name: lfsr_range_rng

Overview:
Parametrised pseudo-random number source for game logic, e.g. horizontal block spawn position. A free-running Fibonacci LFSR has a configurable width and tap mask. Samples are produced on a req/valid handshake, stirred for a set number of shifts, then reduced exactly into 0..MAX_VAL by iterative modulo. A seed port lets the game re-seed from a user-timed event such as a button press.

Parameters:
WIDTH, 10, LFSR and output width in bits (4..32).
TAPS, 10'h240, feedback tap mask; bit i set means lfsr[i] is XORed into feedback. The default uses bits 9 and 6.
SHIFTS, 10, extra shift cycles between accepting req and capturing the sample (>=1).
MAX_VAL, 530, inclusive upper bound of the output range; must be < 2^WIDTH-1.
RESET_RND, 300, value of rnd after reset; must be <= MAX_VAL.

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
seed_load  in  1  load seed into LFSR this cycle
seed  in  WIDTH  seed value; zero is replaced by all-ones
req  in  1  request a new sample; sampled only in IDLE
busy  out  1  high in SHIFT and REDUCE
rnd_valid  out  1  one-cycle pulse: rnd updated this cycle
rnd  out  WIDTH  last reduced sample, held between pulses

Behaviour:
- Reset (async): lfsr=all-ones, state=IDLE, shift count=0, busy=0, rnd_valid=0, rnd=RESET_RND.
- LFSR advances every clock in every state: lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- Lock-up guard: if lfsr_next would be zero, load all-ones instead.
- seed_load has highest priority:
  - lfsr <= (seed==0 ? all-ones : seed).
  - FSM forced to IDLE and shift count cleared. An in-flight request is aborted and no rnd_valid is issued.
  - rnd is unchanged.
  - A req in the same cycle is ignored.
- FSM states:
  - IDLE: busy=0. If req=1 (and no seed_load), go to SHIFT with count=0.
  - SHIFT: count increments each cycle. When count==SHIFTS-1, capture the post-shift LFSR value into work register w and go to REDUCE.
  - REDUCE: each cycle, if w > MAX_VAL then w <= w-(MAX_VAL+1); else rnd <= w, rnd_valid=1 for that cycle, go to IDLE.
- req is ignored outside IDLE; there is no queueing.
- A req held high continuously issues back-to-back samples. IDLE re-accepts on the cycle after the rnd_valid pulse.
- Latency from the req-sampling edge to the rnd_valid-high cycle is SHIFTS + 1 + k cycles.
  - k = floor(w_captured/(MAX_VAL+1)), at most (2^WIDTH-1)/(MAX_VAL+1). For the defaults k is 0 or 1.
- Result equals w_captured mod (MAX_VAL+1), always in 0..MAX_VAL. Subtraction is done at WIDTH bits and never underflows.
- rst mid-operation returns to the reset state immediately; no rnd_valid is issued.

Decomposition:
- Shared package: state enum (IDLE, SHIFT, REDUCE) and an lfsr_step function (tap-mask XOR plus lock-up guard). Game-level constants (e.g. the screen-width MAX_VAL) live in the game package.
- One natural sub-module, lfsr_core: free-running register with seed load and lock-up guard, parametrised by WIDTH/TAPS.
- FSM and modulo reduction stay in lfsr_range_rng.

Test Plan:
- Reset then idle, defaults -> rnd=300, rnd_valid=0, busy=0.
  - LFSR sequence from reset is 3FF, 3FE, 3FC, 3F8, checked against the reference stepping model.
- Single req after reset -> busy high for SHIFTS+1+k cycles; exactly one rnd_valid pulse.
  - rnd equals the reference model's capture mod 531 and is <= 530.
- Force capture values via seed (SHIFTS=1 bench override):
  - capture 1000 -> rnd=469 after one subtract.
  - capture 531 -> rnd=0.
  - capture 530 -> rnd=530 with k=0.
- seed_load with seed=0 -> next LFSR state is 3FF. seed_load asserted during SHIFT or REDUCE -> FSM goes to IDLE, no rnd_valid, rnd unchanged.
- req held high for 10000 cycles -> every pulse has rnd <= MAX_VAL and pulses are spaced by the exact latency.
  - The LFSR never reaches zero, and the full period 1023 is observed on lfsr for WIDTH=10.
- rst asserted mid-REDUCE -> outputs return to reset values asynchronously; the next req behaves as after a clean reset.
